// File: rtl/writeback_arbiter_if.sv
// Execute-stage to register-file writeback bus: ALU results, MDU handshake,
// issue-time hazard query and the registered register-file write port.
interface writeback_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;

    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;

    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_long;
    logic        stall;

    logic        rf_we;
    logic [4:0]  rf_rdi;
    logic [31:0] rf_rd;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mdu_valid, mdu_rd, mdu_data,
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
        input  mdu_ready, stall, rf_we, rf_rdi, rf_rd
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mdu_valid, mdu_rd, mdu_data,
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
        output mdu_ready, stall, rf_we, rf_rdi, rf_rd
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered MDU results onto the single register-file write port
// and stalls issue on hazards against registers awaiting long-latency results.
module writeback_arbiter #(
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic                 clk,
    input logic                 rst,
    writeback_arbiter_if.slave  bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pending_q, pending_d;
    logic [3:0]       outst_q, outst_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_rdi_q, rf_rdi_d;
    logic [31:0]      rf_rd_q, rf_rd_d;

    logic      full, empty, push, pop, long_acc;
    wb_entry_t sel;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.mdu_valid && bus.mdu_ready;
    // Pop decision uses the registered count, so a push never bypasses to the port.
    assign pop   = !bus.alu_valid && !empty;

    assign bus.mdu_ready = !full && !rst;
    assign bus.stall     = rst || (bus.issue_valid && (
                               pending_q[bus.issue_rs1] ||
                               pending_q[bus.issue_rs2] ||
                               ((bus.issue_rd != '0) && pending_q[bus.issue_rd]) ||
                               (bus.issue_long && (outst_q == 4'(MAX_OUTSTANDING)))));
    assign long_acc      = bus.issue_valid && !bus.stall && bus.issue_long;

    assign bus.rf_we  = rf_we_q;
    assign bus.rf_rdi = rf_rdi_q;
    assign bus.rf_rd  = rf_rd_q;

    always_comb begin
        sel = bus.alu_valid ? wb_entry_t'{rd: bus.alu_rd, data: bus.alu_data}
                            : fifo_q[rd_ptr_q];
        // A slot aimed at x0 is consumed but never reaches the register file.
        rf_we_d  = (bus.alu_valid || pop) && (sel.rd != '0);
        rf_rdi_d = rf_we_d ? sel.rd : '0;
        rf_rd_d  = rf_we_d ? sel.data : '0;

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // Clear on the write edge first so a same-index set takes priority.
        pending_d = pending_q;
        if (rf_we_q) begin
            pending_d[rf_rdi_q] = 1'b0;
        end
        if (long_acc && (bus.issue_rd != '0)) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        outst_d = outst_q;
        if (long_acc && !pop) begin
            outst_d = outst_q + 4'd1;
        end else if (!long_acc && pop) begin
            outst_d = outst_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            outst_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_rdi_q  <= '0;
            rf_rd_q   <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            outst_q   <= outst_d;
            rf_we_q   <= rf_we_d;
            rf_rdi_q  <= rf_rdi_d;
            rf_rd_q   <= rf_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= wb_entry_t'{rd: bus.mdu_rd, data: bus.mdu_data};
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: vector table, directed multi-cycle
// sequences, and randomized traffic against a queue-based reference model.
module tb_writeback_arbiter;
    localparam int DEPTH = 2;
    localparam int MAXO  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_arbiter_if bus();

    writeback_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit model_on = 1'b0;

    // Reference model: result queue, pending set, outstanding count, port regs
    typedef struct {
        bit [4:0]  rd;
        bit [31:0] data;
    } res_t;
    res_t      mq[$];
    bit [31:0] m_pend  = '0;
    int        m_outst = 0;
    bit        m_we    = 1'b0;
    bit [4:0]  m_rdi   = '0;
    bit [31:0] m_rd    = '0;

    function automatic bit m_ready();
        return (rst !== 1'b1) && (mq.size() < DEPTH);
    endfunction

    function automatic bit m_stall();
        if (rst === 1'b1) return 1'b1;
        if (bus.issue_valid !== 1'b1) return 1'b0;
        return m_pend[bus.issue_rs1] || m_pend[bus.issue_rs2] ||
               ((bus.issue_rd != 5'd0) && m_pend[bus.issue_rd]) ||
               (bus.issue_long && (m_outst == MAXO));
    endfunction

    task automatic model_edge();
        bit        acc_push, acc_long, slot;
        bit [4:0]  r;
        bit [31:0] d;
        res_t      e;
        if (rst === 1'b1) begin
            mq.delete();
            m_pend = '0; m_outst = 0; m_we = 1'b0; m_rdi = '0; m_rd = '0;
            return;
        end
        acc_push = bus.mdu_valid && m_ready();
        acc_long = bus.issue_valid && !m_stall() && bus.issue_long;
        if (m_we) m_pend[m_rdi] = 1'b0;
        if (acc_long && bus.issue_rd != 5'd0) m_pend[bus.issue_rd] = 1'b1;
        if (acc_long) m_outst++;
        slot = 1'b1; r = '0; d = '0;
        if (bus.alu_valid) begin
            r = bus.alu_rd; d = bus.alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front(); r = e.rd; d = e.data; m_outst--;
        end else begin
            slot = 1'b0;
        end
        m_we  = slot && (r != 5'd0);
        m_rdi = m_we ? r : 5'd0;
        m_rd  = m_we ? d : 32'd0;
        if (acc_push) mq.push_back('{rd: bus.mdu_rd, data: bus.mdu_data});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Compare against the model (when enabled), advance the model, move past the edge.
    task automatic cyc();
        if (model_on) begin
            chk("m.rf_we",     32'(bus.rf_we),     32'(m_we));
            chk("m.rf_rdi",    32'(bus.rf_rdi),    32'(m_rdi));
            chk("m.rf_rd",     bus.rf_rd,          m_rd);
            chk("m.stall",     32'(bus.stall),     32'(m_stall()));
            chk("m.mdu_ready", 32'(bus.mdu_ready), 32'(m_ready()));
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
        bus.issue_rd = '0; bus.issue_long = 1'b0;
    endtask

    task automatic iss(input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd, input bit lng);
        bus.issue_valid = 1'b1; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
        bus.issue_rd = rd; bus.issue_long = lng;
    endtask

    task automatic mdu(input bit [4:0] rd, input bit [31:0] data);
        bus.mdu_valid = 1'b1; bus.mdu_rd = rd; bus.mdu_data = data;
    endtask

    task automatic alu(input bit [4:0] rd, input bit [31:0] data);
        bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_data = data;
    endtask

    typedef struct {
        bit av; bit [4:0] ard; bit [31:0] adat;
        bit mv; bit [4:0] mrd; bit [31:0] mdat;
        bit iv; bit [4:0] rs1; bit [4:0] rs2; bit [4:0] ird; bit il;
        bit we; bit [4:0] rdi; bit [31:0] rd; bit stall; bit ready;
    } vec_t;
    vec_t tbl[13];

    bit        off_act = 1'b0;
    bit [4:0]  off_rd  = '0;
    bit [31:0] off_data = '0;
    bit [4:0]  owed[$];
    bit        acc_m, acc_l;
    bit [4:0]  lrd;

    initial begin
        //          alu                      mdu                        issue rs1 rs2 rd long          exp we rdi rd  stall ready
        tbl[0]  = '{1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0,        1'b0,5'd0,5'd0,5'd0,1'b0, 1'b0,5'd0,32'h0,        1'b0,1'b1};
        tbl[1]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0,5'd0,5'd0,1'b0, 1'b1,5'd5,32'hDEADBEEF, 1'b0,1'b1};
        tbl[2]  = '{1'b1,5'd0,32'h00001111, 1'b0,5'd0,32'h0,        1'b0,5'd0,5'd0,5'd0,1'b0, 1'b0,5'd0,32'h0,        1'b0,1'b1};
        tbl[3]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0,5'd0,5'd0,1'b0, 1'b0,5'd0,32'h0,        1'b0,1'b1};
        tbl[4]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd1,5'd2,5'd9,1'b1, 1'b0,5'd0,32'h0,        1'b0,1'b1};
        tbl[5]  = '{1'b0,5'd0,32'h0,        1'b1,5'd9,32'hCAFEF00D, 1'b1,5'd9,5'd0,5'd1,1'b0, 1'b0,5'd0,32'h0,        1'b1,1'b1};
        tbl[6]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd0,5'd9,5'd2,1'b0, 1'b0,5'd0,32'h0,        1'b1,1'b1};
        tbl[7]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd0,5'd0,5'd9,1'b0, 1'b1,5'd9,32'hCAFEF00D, 1'b1,1'b1};
        tbl[8]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd9,5'd0,5'd4,1'b0, 1'b0,5'd0,32'h0,        1'b0,1'b1};
        tbl[9]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd0,5'd0,5'd0,1'b1, 1'b0,5'd0,32'h0,        1'b0,1'b1};
        tbl[10] = '{1'b0,5'd0,32'h0,        1'b1,5'd0,32'h00000055, 1'b1,5'd0,5'd0,5'd6,1'b0, 1'b0,5'd0,32'h0,        1'b0,1'b1};
        tbl[11] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0,5'd0,5'd0,1'b0, 1'b0,5'd0,32'h0,        1'b0,1'b1};
        tbl[12] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0,5'd0,5'd0,1'b0, 1'b0,5'd0,32'h0,        1'b0,1'b1};

        // Reset with an MDU result offered: nothing accepted, everything stalled
        idle();
        rst = 1'b1;
        mdu(5'd8, 32'h8888_8888);
        iss(5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("rst1.stall", 32'(bus.stall), 32'd1);
        chk("rst1.ready", 32'(bus.mdu_ready), 32'd0);
        cyc();
        #1;
        chk("rst2.stall", 32'(bus.stall), 32'd1);
        chk("rst2.ready", 32'(bus.mdu_ready), 32'd0);
        chk("rst2.rf_we", 32'(bus.rf_we), 32'd0);
        cyc();
        rst = 1'b0;
        idle();
        iss(5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("rel.ready", 32'(bus.mdu_ready), 32'd1);
        chk("rel.stall", 32'(bus.stall), 32'd0);
        chk("rel.rf_we", 32'(bus.rf_we), 32'd0);
        chk("rel.rf_rdi", 32'(bus.rf_rdi), 32'd0);
        cyc();

        // Vector table: ALU path, x0 writes, RAW/WAW on one long op
        for (int i = 0; i < 13; i++) begin
            idle();
            bus.alu_valid = tbl[i].av; bus.alu_rd = tbl[i].ard; bus.alu_data = tbl[i].adat;
            bus.mdu_valid = tbl[i].mv; bus.mdu_rd = tbl[i].mrd; bus.mdu_data = tbl[i].mdat;
            bus.issue_valid = tbl[i].iv; bus.issue_rs1 = tbl[i].rs1; bus.issue_rs2 = tbl[i].rs2;
            bus.issue_rd = tbl[i].ird; bus.issue_long = tbl[i].il;
            #1;
            chk($sformatf("tbl%0d.rf_we", i), 32'(bus.rf_we), 32'(tbl[i].we));
            chk($sformatf("tbl%0d.rf_rdi", i), 32'(bus.rf_rdi), 32'(tbl[i].rdi));
            chk($sformatf("tbl%0d.rf_rd", i), bus.rf_rd, tbl[i].rd);
            chk($sformatf("tbl%0d.stall", i), 32'(bus.stall), 32'(tbl[i].stall));
            chk($sformatf("tbl%0d.ready", i), 32'(bus.mdu_ready), 32'(tbl[i].ready));
            cyc();
        end

        // Contention: ALU holds the port for 4 cycles while the FIFO fills
        for (int i = 0; i < 3; i++) begin
            idle();
            iss(5'd0, 5'd0, (i == 0) ? 5'd7 : 5'(9 + i), 1'b1);
            #1;
            chk($sformatf("cont.pre%0d.stall", i), 32'(bus.stall), 32'd0);
            cyc();
        end
        for (int c = 0; c < 9; c++) begin
            idle();
            if (c < 4) alu(5'd20, 32'hA0 + 32'(c));
            if (c == 0) mdu(5'd7, 32'h12345678);
            if (c == 1) mdu(5'd10, 32'h1010_1010);
            if (c >= 2 && c <= 5) mdu(5'd11, 32'h1111_1111);
            #1;
            if (c >= 1 && c <= 4) begin
                chk($sformatf("cont.c%0d.rf_rdi", c), 32'(bus.rf_rdi), 32'd20);
                chk($sformatf("cont.c%0d.rf_rd", c), bus.rf_rd, 32'hA0 + 32'(c - 1));
            end
            chk($sformatf("cont.c%0d.ready", c), 32'(bus.mdu_ready), (c >= 2 && c <= 4) ? 32'd0 : 32'd1);
            if (c == 5) chk("cont.c5.rf_rdi", 32'(bus.rf_rdi), 32'd7);
            if (c == 5) chk("cont.c5.rf_rd", bus.rf_rd, 32'h12345678);
            if (c == 6) chk("cont.c6.rf_rdi", 32'(bus.rf_rdi), 32'd10);
            if (c == 7) chk("cont.c7.rf_rd", bus.rf_rd, 32'h1111_1111);
            chk($sformatf("cont.c%0d.rf_we", c), 32'(bus.rf_we), (c == 0 || c == 8) ? 32'd0 : 32'd1);
            cyc();
        end

        // RAW on rs1 against an outstanding long op
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c == 0) iss(5'd0, 5'd0, 5'd3, 1'b1);
            else iss(5'd3, 5'd0, 5'd5, 1'b0);
            if (c == 2) mdu(5'd3, 32'h0000_0033);
            #1;
            chk($sformatf("raw.c%0d.stall", c), 32'(bus.stall), (c == 0 || c == 5) ? 32'd0 : 32'd1);
            if (c == 4) chk("raw.c4.rf_rdi", 32'(bus.rf_rdi), 32'd3);
            if (c == 4) chk("raw.c4.rf_we", 32'(bus.rf_we), 32'd1);
            cyc();
        end

        // Outstanding limit: 5th long op waits for one MDU write-select
        for (int c = 0; c < 9; c++) begin
            idle();
            if (c < 4) iss(5'd0, 5'd0, 5'(12 + c), 1'b1);
            else if (c == 5) iss(5'd0, 5'd0, 5'd17, 1'b0);
            else iss(5'd0, 5'd0, 5'd16, 1'b1);
            if (c == 6) mdu(5'd12, 32'h0000_0C0C);
            #1;
            chk($sformatf("lim.c%0d.stall", c), 32'(bus.stall),
                (c == 4 || c == 6 || c == 7) ? 32'd1 : 32'd0);
            cyc();
        end

        idle();
        rst = 1'b1;
        #1; cyc();
        #1; cyc();
        rst = 1'b0;

        // Randomized traffic against the reference model
        model_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            bus.alu_valid = ($urandom_range(0, 2) == 0);
            bus.alu_rd    = 5'($urandom);
            bus.alu_data  = $urandom;
            if (!off_act && owed.size() > 0 && $urandom_range(0, 1) == 1) begin
                off_act = 1'b1; off_rd = owed[0]; off_data = $urandom;
            end
            bus.mdu_valid = off_act; bus.mdu_rd = off_rd; bus.mdu_data = off_data;
            bus.issue_valid = ($urandom_range(0, 1) == 1);
            bus.issue_rs1   = 5'($urandom_range(0, 7));
            bus.issue_rs2   = 5'($urandom_range(0, 7));
            bus.issue_rd    = 5'($urandom_range(0, 7));
            bus.issue_long  = ($urandom_range(0, 2) == 0);
            #1;
            acc_m = bus.mdu_valid && m_ready();
            acc_l = bus.issue_valid && !m_stall() && bus.issue_long;
            lrd   = bus.issue_rd;
            cyc();
            if (rst) begin
                owed.delete();
                off_act = 1'b0;
            end else begin
                if (acc_m) begin
                    void'(owed.pop_front());
                    off_act = 1'b0;
                end
                if (acc_l) owed.push_back(lrd);
            end
        end
        model_on = 1'b0;
        rst = 1'b0;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
